// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One radix-2 step per clock: 32 iterations plus a sign-fix/writeback cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state, state_nxt;
  logic        is_div;
  logic [31:0] a_r, b_r;
  logic        sign_a, sign_b;
  logic [4:0]  cnt;
  logic [63:0] acc;

  logic        in_sign_a, in_sign_b;
  logic [31:0] abs_rs, abs_rt;
  logic [32:0] mul_sum;
  logic [64:0] div_sh;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] acc_step;
  logic        neg;
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix, rs_orig;

  always_comb begin
    in_sign_a = ~op[0] & rs_val[31];
    in_sign_b = ~op[0] & rt_val[31];
    abs_rs    = in_sign_a ? -rs_val : rs_val;
    abs_rt    = in_sign_b ? -rt_val : rt_val;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide:   acc = {partial remainder, dividend/quotient bits}, shifted left.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_r} : 33'd0);
    div_sh   = {acc, 1'b0};
    div_ge   = div_sh[64:32] >= {1'b0, b_r};
    div_diff = div_sh[63:32] - b_r;
    if (is_div)
      acc_step = div_ge ? {div_diff, div_sh[31:1], 1'b1} : div_sh[63:0];
    else
      acc_step = {mul_sum, acc[31:1]};
  end

  always_comb begin
    neg      = sign_a ^ sign_b;
    prod_fix = neg ? -acc : acc;
    q_fix    = neg ? -acc[31:0] : acc[31:0];
    r_fix    = sign_a ? -acc[63:32] : acc[63:32];
    rs_orig  = sign_a ? -a_r : a_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_div <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            a_r    <= abs_rs;
            b_r    <= abs_rt;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            cnt    <= '0;
            acc    <= op[1] ? {32'd0, abs_rs} : {32'd0, abs_rt};
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
        end
        FIN: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else if (b_r == '0) begin
            hi <= rs_orig;
            lo <= '1;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk, rst, start, wr_hi, wr_lo, busy, done;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata, hi, lo;
  int unsigned n_pass, n_total;
  logic        saw_done;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issues one operation, counts busy cycles, checks done pulse and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit glitch,
                        input bit chk_lo, input logic [31:0] exp_wlo);
    int unsigned cyc;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    check({tag, "_accept_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    if (chk_lo) check({tag, "_wlo"}, lo, exp_wlo);
    cyc = 1;
    while (busy && cyc < 40) begin
      if (glitch && cyc == 5) begin
        start = 1'b1; op = ~o; rs_val = 32'h1357_9BDF; rt_val = 32'h0000_0003;
      end
      if (glitch && cyc == 6) start = 1'b0;
      @(posedge clk); #1;
      if (busy) cyc++;
    end
    check({tag, "_busy_cycles"}, cyc, 32'd33);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // start presented together with reset release: first edge must accept it
    run_op("mult", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, '0);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, '0);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, '0);
    run_op("divu_by0", 2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 0, 0, '0);
    run_op("div_by0_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 0, '0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0, '0);
    // issued while done is high, with a start pulse and operand changes mid-run
    run_op("b2b_divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1, 0, '0);
    run_op("div_7_m2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0, '0);

    // abort sequence: direct write while busy, then reset at iteration 10
    op = 2'b00; rs_val = 32'd5; rt_val = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    wr_hi = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    check("wr_hi_busy", hi, 32'h0000_0001);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_hold_hi", hi, 32'd0);
    check("abort_hold_lo", lo, 32'd0);

    wr_hi = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    check("wr_hi_idle", hi, 32'h0000_1234);
    repeat (3) begin @(posedge clk); #1; end
    check("hold_hi", hi, 32'h0000_1234);
    check("hold_lo", lo, 32'd0);

    // direct write together with start: write lands, FIN overwrites
    wr_lo = 1'b1; wdata = 32'h0000_ABCD;
    run_op("wlo_start", 2'b00, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 1, 32'h0000_ABCD);
    @(posedge clk); #1;
    check("final_done_low", {31'd0, done}, 32'd0);
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 start  in  1  request a new operation; sampled only in IDLE.
REQ-005 op  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 rs_val  in  32  multiplicand / dividend.
REQ-007 rt_val  in  32  multiplier / divisor.
REQ-008 wr_hi  in  1  direct write of hi from wdata (mthi path).
REQ-009 wr_lo  in  1  direct write of lo from wdata (mtlo path).
REQ-010 wdata  in  32  data for wr_hi / wr_lo.
REQ-011 busy  out  1  high while an operation is in progress; the pipeline stalls mfhi/mflo/mult/div on it.
REQ-012 done  out  1  one-cycle pulse when hi/lo receive a new result.
REQ-013 hi  out  32  HI register; product[63:32] or remainder.
REQ-014 lo  out  32  LO register; product[31:0] or quotient.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FIN; busy SHALL be (state != IDLE).
REQ-016 IDLE with start=1 at edge E0: latch op, |rs_val| and |rt_val| (signed ops) or raw values (unsigned ops) plus the sign bits; clear the 5-bit iteration counter; go to RUN.
REQ-017 RUN SHALL perform one iteration per edge, for exactly 32 edges (E1..E32), then go to FIN.
- Multiply iteration: radix-2 shift-add into a 64-bit accumulator.
- Divide iteration: restoring shift-subtract producing one quotient bit.
REQ-018 FIN (edge E33) SHALL apply sign correction, write hi and lo, assert done for the following cycle, and return to IDLE.
- Total latency is 33 edges after E0; busy is high for 33 cycles.
REQ-019 Signed mult: negate the 64-bit product when the operand signs differ; multu: no correction.
REQ-020 Signed div: negate the quotient when the operand signs differ; the remainder takes the sign of the dividend; divu: no correction.
REQ-021 Divide by zero (div or divu) SHALL yield lo=0xFFFFFFFF and hi=the original rs_val, with no exception and the same 33-edge latency.
REQ-022 div 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000.
REQ-023 start while busy SHALL be ignored; rs_val, rt_val and op changes while busy SHALL have no effect.
REQ-024 start in the cycle done is high (state IDLE) SHALL be accepted; back-to-back operations lose no cycle.
REQ-025 wr_hi / wr_lo SHALL write at the edge only when IDLE and SHALL be ignored while busy.
REQ-026 wr_hi/wr_lo together with start in the same IDLE cycle SHALL apply the write; the operation still starts, and its FIN result overwrites hi/lo.
REQ-027 hi and lo SHALL hold their value in every cycle without a FIN write or an accepted direct write.
REQ-028 done SHALL be registered, high for exactly one cycle per completed operation, and never high in IDLE without a preceding FIN.

Reset
REQ-029 rst=1 SHALL force immediately, regardless of clk: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, internal accumulators cleared.
REQ-030 rst asserted mid-operation SHALL abort it: no done pulse, no hi/lo update after reset release.
REQ-031 The first start after reset release SHALL be accepted on the first rising edge with rst=0.

Verification
REQ-032 mult 0xFFFFFFFE x 0x00000003 -> after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse of 1 cycle, busy high for 33 cycles.
REQ-033 multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-035 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; then start issued while done=1 -> accepted; a start pulse mid-run -> ignored, and the result matches the first operands.
REQ-036 rst pulsed at RUN iteration 10 -> busy=0 and hi=lo=0 immediately, no done pulse; wr_hi with 0x1234 while busy -> hi unchanged, while IDLE -> hi=0x00001234.
